prog_sequencer: RTL
===================

# prog_sequencer

Loads a program image into the FSM controller's instruction memory from a byte-stream source. It validates a framed image (magic byte, length, payload, checksum) and forwards each payload byte to the controller's programming port as a one-cycle `prog_enable` strobe. It reports success by asserting `run`, or failure through `error_code`. It sits between the chip-level byte input and the controller's `prog_enable`/`data_in` pins; the top level releases the controller's `in` path only while `run` is high.

## Interface
- `PROG_BYTES`, default 48: exact payload length in bytes, equal to the instruction memory image size; range 1..255.
- `TIMEOUT`, default 1024: number of consecutive stall cycles tolerated mid-frame; must be ≥ 2.
- `MAGIC`, default 8'hA5: required first byte of every frame.

Ports:
- `clock` in 1: clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: single-cycle pulse; (re)starts a load from any state.
- `byte_valid` in 1: source has a byte on `byte_data`.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: sequencer accepts a byte; accept occurs when `byte_valid && byte_ready`.
- `prog_enable` out 1: registered; high for exactly one cycle per payload byte.
- `prog_data` out 8: registered payload byte, valid while `prog_enable` is high.
- `run` out 1: registered; image loaded and checksum good.
- `busy` out 1: registered; a frame is in progress.
- `error_code` out 3: registered. Codes: 000 none, 001 bad magic, 010 bad length, 011 bad checksum, 100 timeout.

## Operation
- States: `IDLE`, `MAGIC`, `LEN`, `LOAD`, `CSUM`, `RUN`, `ERROR`.
- `byte_ready` is combinational: 1 in `MAGIC`/`LEN`/`LOAD`/`CSUM`/`ERROR`, 0 in `IDLE`/`RUN`. It is forced to 0 in any cycle where `start` is high.
- `start` has priority over every other event. On `start`:
  - next state is `MAGIC`;
  - `run` and `error_code` clear;
  - checksum and timeout counters clear;
  - any handshake in that cycle is ignored (`byte_ready` is 0, so none occurs).
- `MAGIC`: on accept, `byte_data == MAGIC` moves to `LEN`; any other value moves to `ERROR` with code 001.
- `LEN`: on accept, `byte_data == PROG_BYTES` moves to `LOAD`, with the remaining-byte counter set to `PROG_BYTES` and the sum cleared. Any other value moves to `ERROR` with code 010.
- `LOAD`: on each accept:
  - `prog_enable` is 1 and `prog_data = byte_data` in the next cycle;
  - sum = (sum + byte) mod 256;
  - the remaining counter decrements.
  - When the counter reaches 0 after this accept, the next state is `CSUM`.
- `CSUM`: on accept, `byte_data == sum` moves to `RUN` (`run` = 1). Otherwise the next state is `ERROR` with code 011. Payload bytes already forwarded are not retracted; `run` stays 0.
- `RUN`: `run` = 1 and `byte_ready` = 0. The block holds in `RUN` until `start` or reset.
- `ERROR`: `error_code` holds. `byte_ready` = 1 and every accepted byte is discarded. `prog_enable` stays 0. The block leaves `ERROR` only on `start` or reset.
- Timeout:
  - In `LEN`/`LOAD`/`CSUM`, a stall counter increments on every cycle with no accept.
  - The counter clears on an accept and on entry to `MAGIC`.
  - A no-accept cycle with counter == `TIMEOUT-1` moves to `ERROR` with code 100.
  - An accept in that same cycle wins: there is no timeout.
  - `MAGIC` never times out.
- `busy` = 1 in `MAGIC`/`LEN`/`LOAD`/`CSUM`, 0 otherwise.
- Width rules: the remaining counter is 8 bits; the stall counter is `$clog2(TIMEOUT)` bits and saturates at its terminal value; the checksum is 8-bit with carry discarded.

## Timing
- Reset values: state `IDLE`, `prog_enable` 0, `prog_data` 8'h00, `run` 0, `busy` 0, `error_code` 000; all counters 0. `byte_ready` is 0 in `IDLE`.
- Latency:
  - A payload byte accepted at edge t appears on `prog_data` with `prog_enable` = 1 during cycle t+1.
  - With continuous valid bytes, `prog_enable` is high on `PROG_BYTES` consecutive cycles.
  - A checksum byte accepted at edge t gives `run` = 1 from cycle t+1.
  - `error_code` is set in the cycle after the offending accept or timeout.
- `start` at edge t: `busy` = 1 and `run` = 0 from cycle t+1. A `prog_enable` already scheduled from an accept at edge t-1 still occurs in cycle t. No further `prog_enable` follows until a new `LOAD`.
- Minimum load time: `PROG_BYTES` + 3 accepts, so `PROG_BYTES` + 3 cycles from the first `MAGIC` accept to `run`.
- Reset asserted mid-load wins over every other event and returns all outputs to their reset values at the next edge.

## Test plan
- Use `PROG_BYTES`=4 and `TIMEOUT`=8.
- Good frame: `start`, then A5, 04, 01 02 03 04, 0A streamed back-to-back. Required: `prog_enable` high for 4 cycles carrying 01..04, then `run`=1, `busy`=0, `error_code`=000.
- Bad magic / bad length / bad checksum:
  - first byte 5A gives `error_code`=001;
  - length 03 gives 010;
  - checksum 0B gives 011, after exactly 4 `prog_enable` pulses.
  - In all three cases `run`=0, and trailing bytes are accepted but produce no `prog_enable`.
- Stall and timeout:
  - After A5, 04, 01, `byte_valid` low for 7 cycles and then byte 02 is presented: the load continues.
  - With 8 idle cycles instead, `error_code`=100 the cycle after the 8th.
- Backpressure: `byte_valid` toggling 1,0,1,0 through a good frame. Required: one `prog_enable` per accepted payload byte, correct checksum, `run`=1.
- Restart and reset:
  - `start` pulsed after the 2nd payload byte, in the same cycle as a valid byte: that byte is not accepted, `busy` stays 1, state returns to `MAGIC`, and a full good frame then succeeds.
  - `rst_n`=0 during `LOAD` clears all outputs at the next edge.

Source files
------------

// File: rtl/prog_sequencer.sv
// prog_sequencer
//   Loads a program image from a byte stream into the FSM controller's
//   instruction memory. The frame carries a magic byte, a length byte,
//   PROG_BYTES payload bytes and an 8-bit additive checksum. Each payload
//   byte is forwarded as a one-cycle prog_enable strobe. The result is
//   reported on run (success) or error_code (failure).
//
// Ports
//   clock       : rising-edge clock
//   rst_n       : synchronous active-low reset
//   start       : one-cycle pulse that (re)starts a load from any state
//   byte_valid  : source presents byte_data
//   byte_data   : stream byte (8 bits)
//   byte_ready  : sequencer accepts; transfer when byte_valid && byte_ready
//   prog_enable : one-cycle strobe per payload byte (registered)
//   prog_data   : payload byte, valid while prog_enable is high (registered)
//   run         : image loaded and checksum good (registered)
//   busy        : frame in progress (registered)
//   error_code  : 000 none, 001 magic, 010 length, 011 checksum, 100 timeout
module prog_sequencer #(
  parameter int         PROG_BYTES = 48,
  parameter int         TIMEOUT    = 1024,
  parameter logic [7:0] MAGIC      = 8'hA5
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       start,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       prog_enable,
  output logic [7:0] prog_data,
  output logic       run,
  output logic       busy,
  output logic [2:0] error_code
);

  localparam int SW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STALL_TERM = SW'(TIMEOUT - 1);

  localparam logic [2:0] ERR_NONE  = 3'b000;
  localparam logic [2:0] ERR_MAGIC = 3'b001;
  localparam logic [2:0] ERR_LEN   = 3'b010;
  localparam logic [2:0] ERR_CSUM  = 3'b011;
  localparam logic [2:0] ERR_TMO   = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_MAGIC, S_LEN, S_LOAD, S_CSUM, S_RUN, S_ERROR
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    rem_cnt, rem_nx;
  logic [7:0]    sum, sum_nx;
  logic [SW-1:0] stall_cnt, stall_nx;
  logic [2:0]    err_nx;
  logic          pe_nx;
  logic [7:0]    pd_nx;
  logic          accept;

  // Checksum: 8-bit sum, carry discarded.
  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  // Stall counter increments but never wraps past its terminal value.
  function automatic logic [SW-1:0] stall_inc(input logic [SW-1:0] c);
    return (c == STALL_TERM) ? c : c + SW'(1);
  endfunction

  always_comb begin
    byte_ready = 1'b0;
    if (!start && (state inside {S_MAGIC, S_LEN, S_LOAD, S_CSUM, S_ERROR}))
      byte_ready = 1'b1;
    accept   = byte_valid && byte_ready;

    state_nx = state;
    rem_nx   = rem_cnt;
    sum_nx   = sum;
    stall_nx = stall_cnt;
    err_nx   = error_code;
    pe_nx    = 1'b0;
    pd_nx    = prog_data;

    if (start) begin
      state_nx = S_MAGIC;
      rem_nx   = 8'd0;
      sum_nx   = 8'd0;
      stall_nx = '0;
      err_nx   = ERR_NONE;
    end else begin
      case (state)
        S_MAGIC: begin
          if (accept) begin
            stall_nx = '0;
            if (byte_data == MAGIC) state_nx = S_LEN;
            else begin
              state_nx = S_ERROR;
              err_nx   = ERR_MAGIC;
            end
          end
        end
        S_LEN, S_LOAD, S_CSUM: begin
          if (accept) begin
            stall_nx = '0;
            if (state == S_LEN) begin
              if (byte_data == 8'(PROG_BYTES)) begin
                state_nx = S_LOAD;
                rem_nx   = 8'(PROG_BYTES);
                sum_nx   = 8'd0;
              end else begin
                state_nx = S_ERROR;
                err_nx   = ERR_LEN;
              end
            end else if (state == S_LOAD) begin
              pe_nx  = 1'b1;
              pd_nx  = byte_data;
              sum_nx = csum_add(sum, byte_data);
              rem_nx = rem_cnt - 8'd1;
              if (rem_cnt == 8'd1) state_nx = S_CSUM;
            end else begin
              if (byte_data == sum) state_nx = S_RUN;
              else begin
                state_nx = S_ERROR;
                err_nx   = ERR_CSUM;
              end
            end
          end else if (stall_cnt == STALL_TERM) begin
            // An accept in the terminal cycle is handled above, so it wins.
            state_nx = S_ERROR;
            err_nx   = ERR_TMO;
          end else begin
            stall_nx = stall_inc(stall_cnt);
          end
        end
        default: ;  // IDLE, RUN, ERROR hold until start or reset
      endcase
    end
  end

  // Registered state and outputs; run/busy decode from the next state.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rem_cnt     <= 8'd0;
      sum         <= 8'd0;
      stall_cnt   <= '0;
      prog_enable <= 1'b0;
      prog_data   <= 8'h00;
      run         <= 1'b0;
      busy        <= 1'b0;
      error_code  <= ERR_NONE;
    end else begin
      state       <= state_nx;
      rem_cnt     <= rem_nx;
      sum         <= sum_nx;
      stall_cnt   <= stall_nx;
      prog_enable <= pe_nx;
      prog_data   <= pd_nx;
      run         <= (state_nx == S_RUN);
      busy        <= (state_nx inside {S_MAGIC, S_LEN, S_LOAD, S_CSUM});
      error_code  <= err_nx;
    end
  end

endmodule
